// File: rtl/legv8_pkg.sv
// Shared LEGv8 opcode constants and field positions, used by both the
// control decoder and the instruction encoder so the two cannot drift apart.
package legv8_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_AND  = 3'd2,
      OP_ORR  = 3'd3,
      OP_LDUR = 3'd4,
      OP_STUR = 3'd5,
      OP_CBZ  = 3'd6,
      OP_ILL  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_FULL = 2'd2
   } enc_state_e;

   localparam logic [10:0] OPC_ADD  = 11'b10001011000;
   localparam logic [10:0] OPC_SUB  = 11'b11001011000;
   localparam logic [10:0] OPC_AND  = 11'b10001010000;
   localparam logic [10:0] OPC_ORR  = 11'b10101010000;
   localparam logic [10:0] OPC_LDUR = 11'b11111000010;
   localparam logic [10:0] OPC_STUR = 11'b11111000000;
   localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

   localparam int RD_LSB    = 0;
   localparam int RN_LSB    = 5;
   localparam int RM_LSB    = 16;
   localparam int OPC_LSB   = 21;
   localparam int DIMM_LSB  = 12;
   localparam int CBIMM_LSB = 5;
   localparam int CBOPC_LSB = 24;

endpackage

// File: rtl/legv8_field_pack.sv
// Combinational packing of one symbolic request into a 32-bit LEGv8 word,
// flagging requests that cannot be encoded.
module legv8_field_pack
   import legv8_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [4:0]  rd,
   input  logic [4:0]  rn,
   input  logic [4:0]  rm,
   input  logic [18:0] imm,
   output logic [31:0] word,
   output logic        illegal
);

   logic imm_overflow;

   // D-type offsets are 9-bit signed; the upper bits must be pure sign extension.
   assign imm_overflow = (imm[18:9] != {10{imm[8]}});

   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (op_e'(op))
         OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
            case (op_e'(op))
               OP_ADD:  word[OPC_LSB +: 11] = OPC_ADD;
               OP_SUB:  word[OPC_LSB +: 11] = OPC_SUB;
               OP_AND:  word[OPC_LSB +: 11] = OPC_AND;
               default: word[OPC_LSB +: 11] = OPC_ORR;
            endcase
            word[RM_LSB +: 5] = rm;
            word[RN_LSB +: 5] = rn;
            word[RD_LSB +: 5] = rd;
         end
         OP_LDUR, OP_STUR: begin
            word[OPC_LSB +: 11] = (op_e'(op) == OP_LDUR) ? OPC_LDUR : OPC_STUR;
            word[DIMM_LSB +: 9] = imm[8:0];
            word[RN_LSB +: 5]   = rn;
            word[RD_LSB +: 5]   = rd;
            illegal             = imm_overflow;
         end
         OP_CBZ: begin
            word[CBOPC_LSB +: 8]  = OPC_CBZ;
            word[CBIMM_LSB +: 19] = imm;
            word[RD_LSB +: 5]     = rd;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/legv8_instr_encoder.sv
// Assembles LEGv8 instruction words from symbolic requests and streams them
// into instruction memory at consecutive addresses, one word per cycle.
module legv8_instr_encoder
   import legv8_pkg::*;
#(
   parameter int ADDR_W    = 6,
   parameter int DEPTH     = 64,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rn,
   input  logic [4:0]        in_rm,
   input  logic [18:0]       in_imm,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              err,
   output logic              err_sticky
);

   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

   enc_state_e        state;
   logic [31:0]       packed_word;
   logic              packed_illegal;
   logic [ADDR_W+1:0] occupancy;
   logic [ADDR_W:0]   count_next;
   logic              full_pending;
   logic              accept;
   logic              done;

   legv8_field_pack u_pack (
      .op      (in_op),
      .rd      (in_rd),
      .rn      (in_rn),
      .rm      (in_rm),
      .imm     (in_imm),
      .word    (packed_word),
      .illegal (packed_illegal)
   );

   // A pending word counts against capacity, so the last slot is never overbooked.
   assign occupancy    = {1'b0, count} + {{(ADDR_W+1){1'b0}}, mem_we};
   assign full_pending = (occupancy == {1'b0, DEPTH_C});
   assign count_next   = count + 1'b1;
   assign in_ready     = !rst && !clear && !full_pending && (!mem_we || mem_ready);
   assign accept       = in_valid && in_ready;
   assign done         = mem_we && mem_ready;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state      <= ST_IDLE;
         mem_we     <= 1'b0;
         mem_wdata  <= '0;
         mem_addr   <= BASE_C;
         count      <= '0;
         full       <= 1'b0;
         err        <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         err <= 1'b0;
         if (accept && packed_illegal) begin
            err        <= 1'b1;
            err_sticky <= 1'b1;
         end
         if (done) begin
            mem_addr <= mem_addr + 1'b1;
            count    <= count_next;
         end
         case (state)
            ST_IDLE: begin
               if (accept && !packed_illegal) begin
                  mem_we    <= 1'b1;
                  mem_wdata <= packed_word;
                  state     <= ST_PEND;
               end
            end
            ST_PEND: begin
               if (done) begin
                  if (count_next == DEPTH_C) begin
                     mem_we <= 1'b0;
                     full   <= 1'b1;
                     state  <= ST_FULL;
                  end else if (accept && !packed_illegal) begin
                     mem_wdata <= packed_word;
                  end else begin
                     mem_we <= 1'b0;
                     state  <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_FULL;
         endcase
      end
   end

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Scoreboard bench for the LEGv8 instruction encoder: expected words are queued
// at acceptance and matched against memory writes as they complete.
module tb_legv8_instr_encoder;

   localparam int ADDR_W = 6;
   localparam int DEPTH  = 4;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } sb_t;

   logic              clk;
   logic              rst;
   logic              clear;
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_op;
   logic [4:0]        in_rd;
   logic [4:0]        in_rn;
   logic [4:0]        in_rm;
   logic [18:0]       in_imm;
   logic              mem_we;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              err;
   logic              err_sticky;

   int compared   = 0;
   int mismatched = 0;

   sb_t               sb_q[$];
   logic [ADDR_W-1:0] exp_addr = '0;
   logic              pending_err = 1'b0;

   legv8_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(0)) dut (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_rd      (in_rd),
      .in_rn      (in_rn),
      .in_rm      (in_rm),
      .in_imm     (in_imm),
      .mem_we     (mem_we),
      .mem_ready  (mem_ready),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .count      (count),
      .full       (full),
      .err        (err),
      .err_sticky (err_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Reference encoding written directly from the LEGv8 format tables.
   function automatic logic [32:0] modelEncode(input logic [2:0] op, input logic [4:0] rd,
                                               input logic [4:0] rn, input logic [4:0] rm,
                                               input logic [18:0] imm);
      logic bad;
      bad = (imm[18:9] != {10{imm[8]}});
      case (op)
         3'd0:    return {1'b0, 11'b10001011000, rm, 6'b000000, rn, rd};
         3'd1:    return {1'b0, 11'b11001011000, rm, 6'b000000, rn, rd};
         3'd2:    return {1'b0, 11'b10001010000, rm, 6'b000000, rn, rd};
         3'd3:    return {1'b0, 11'b10101010000, rm, 6'b000000, rn, rd};
         3'd4:    return {bad, 11'b11111000010, imm[8:0], 2'b00, rn, rd};
         3'd5:    return {bad, 11'b11111000000, imm[8:0], 2'b00, rn, rd};
         3'd6:    return {1'b0, 8'b10110100, imm, rd};
         default: return {1'b1, 32'h0};
      endcase
   endfunction

   // Monitor samples on the falling edge, midway between stimulus and the active edge.
   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
         exp_addr    = '0;
         pending_err = 1'b0;
      end else begin
         logic [32:0] enc;
         sb_t         item;
         checkOutput("err_pulse", {31'b0, err}, {31'b0, pending_err});
         if (clear) begin
            sb_q.delete();
            exp_addr    = '0;
            pending_err = 1'b0;
         end else begin
            if (mem_we && mem_ready) begin
               if (sb_q.size() == 0) begin
                  checkOutput("unexpected_write", 32'd1, 32'd0);
               end else begin
                  item = sb_q.pop_front();
                  checkOutput("sb_addr", {26'b0, mem_addr}, {26'b0, item.addr});
                  checkOutput("sb_data", mem_wdata, item.data);
               end
            end
            pending_err = 1'b0;
            if (in_valid && in_ready) begin
               enc = modelEncode(in_op, in_rd, in_rn, in_rm, in_imm);
               if (enc[32]) begin
                  pending_err = 1'b1;
               end else begin
                  item.addr = exp_addr;
                  item.data = enc[31:0];
                  sb_q.push_back(item);
                  exp_addr  = exp_addr + 1'b1;
               end
            end
         end
      end
   end

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic driveFields(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rn,
                              input logic [4:0] rm, input logic [18:0] imm);
      in_op    = op;
      in_rd    = rd;
      in_rn    = rn;
      in_rm    = rm;
      in_imm   = imm;
      in_valid = 1'b1;
   endtask

   // Holds the request until the handshake completes, then returns one cycle later.
   task automatic applyStimulus(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rn,
                                input logic [4:0] rm, input logic [18:0] imm);
      bit accepted;
      accepted = 1'b0;
      driveFields(op, rd, rn, rm, imm);
      for (int i = 0; i < 40 && !accepted; i++) begin
         @(negedge clk);
         accepted = in_ready;
         nextCycle();
      end
      if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic pulseClear();
      clear = 1'b1;
      nextCycle();
      clear = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
      in_op = 3'd0; in_rd = '0; in_rn = '0; in_rm = '0; in_imm = '0;
      nextCycle();
      @(negedge clk);
      checkOutput("ready_in_reset", {31'b0, in_ready}, 32'd0);
      nextCycle();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_mem_we", {31'b0, mem_we}, 32'd0);
      checkOutput("rst_wdata", mem_wdata, 32'd0);
      checkOutput("rst_addr", {26'b0, mem_addr}, 32'd0);
      checkOutput("rst_count", {25'b0, count}, 32'd0);
      checkOutput("rst_full", {31'b0, full}, 32'd0);
      checkOutput("rst_sticky", {31'b0, err_sticky}, 32'd0);
      nextCycle();

      $display("[TB] ADD single write");
      applyStimulus(3'd0, 5'd1, 5'd2, 5'd3, 19'h5A5A5);
      @(negedge clk);
      checkOutput("add_we", {31'b0, mem_we}, 32'd1);
      checkOutput("add_addr", {26'b0, mem_addr}, 32'd0);
      checkOutput("add_data", mem_wdata, 32'h8B030041);
      nextCycle();
      @(negedge clk);
      checkOutput("add_count", {25'b0, count}, 32'd1);
      checkOutput("add_we_drop", {31'b0, mem_we}, 32'd0);
      nextCycle();
      pulseClear();

      $display("[TB] LDUR then CBZ back-to-back");
      applyStimulus(3'd4, 5'd5, 5'd4, 5'd17, 19'h7FFF8);
      driveFields(3'd6, 5'd7, 5'd31, 5'd31, 19'd3);
      @(negedge clk);
      checkOutput("ldur_addr", {26'b0, mem_addr}, 32'd0);
      checkOutput("ldur_data", mem_wdata, 32'hF85F8085);
      checkOutput("cbz_ready", {31'b0, in_ready}, 32'd1);
      nextCycle();
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("cbz_addr", {26'b0, mem_addr}, 32'd1);
      checkOutput("cbz_data", mem_wdata, 32'hB4000067);
      nextCycle();
      @(negedge clk);
      checkOutput("pair_count", {25'b0, count}, 32'd2);
      nextCycle();
      pulseClear();

      $display("[TB] rejected requests");
      applyStimulus(3'd5, 5'd2, 5'd3, 5'd0, 19'h00200);
      @(negedge clk);
      checkOutput("stur_err", {31'b0, err}, 32'd1);
      checkOutput("stur_sticky", {31'b0, err_sticky}, 32'd1);
      checkOutput("stur_no_we", {31'b0, mem_we}, 32'd0);
      nextCycle();
      @(negedge clk);
      checkOutput("stur_err_drop", {31'b0, err}, 32'd0);
      checkOutput("stur_count", {25'b0, count}, 32'd0);
      nextCycle();
      applyStimulus(3'd7, 5'd1, 5'd1, 5'd1, 19'd0);
      @(negedge clk);
      checkOutput("op7_err", {31'b0, err}, 32'd1);
      checkOutput("op7_no_we", {31'b0, mem_we}, 32'd0);
      checkOutput("op7_addr", {26'b0, mem_addr}, 32'd0);
      nextCycle();
      pulseClear();

      $display("[TB] memory backpressure");
      mem_ready = 1'b0;
      applyStimulus(3'd1, 5'd9, 5'd10, 5'd11, 19'h12345);
      driveFields(3'd3, 5'd31, 5'd0, 5'd31, 19'h7FFFF);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("stall_ready", {31'b0, in_ready}, 32'd0);
         checkOutput("stall_addr", {26'b0, mem_addr}, 32'd0);
         checkOutput("stall_data", mem_wdata, 32'hCB0B0149);
         nextCycle();
      end
      mem_ready = 1'b1;
      @(negedge clk);
      checkOutput("unstall_ready", {31'b0, in_ready}, 32'd1);
      nextCycle();
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("queued_addr", {26'b0, mem_addr}, 32'd1);
      checkOutput("queued_data", mem_wdata, 32'hAA1F001F);
      checkOutput("queued_count", {25'b0, count}, 32'd1);
      nextCycle();
      pulseClear();

      $display("[TB] fill to capacity");
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(3'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 5'($urandom), 19'($urandom));
      end
      driveFields(3'd2, 5'd3, 5'd4, 5'd5, 19'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("full_ready", {31'b0, in_ready}, 32'd0);
         if (i >= 1) begin
            checkOutput("full_flag", {31'b0, full}, 32'd1);
            checkOutput("full_count", {25'b0, count}, 32'(DEPTH));
            checkOutput("full_no_we", {31'b0, mem_we}, 32'd0);
         end
         nextCycle();
      end
      pulseClear();
      @(negedge clk);
      checkOutput("clr_count", {25'b0, count}, 32'd0);
      checkOutput("clr_full", {31'b0, full}, 32'd0);
      checkOutput("clr_addr", {26'b0, mem_addr}, 32'd0);
      checkOutput("clr_ready", {31'b0, in_ready}, 32'd1);
      nextCycle();
      in_valid = 1'b0;
      applyStimulus(3'd6, 5'd12, 5'd0, 5'd0, 19'h40000);
      nextCycle();
      @(negedge clk);
      checkOutput("resume_count", {25'b0, count}, 32'd2);
      nextCycle();

      $display("[TB] reset during stalled write");
      applyStimulus(3'd7, 5'd0, 5'd0, 5'd0, 19'd0);
      mem_ready = 1'b0;
      applyStimulus(3'd4, 5'd8, 5'd9, 5'd0, 19'h000FF);
      repeat (2) nextCycle();
      @(negedge clk);
      checkOutput("pre_rst_we", {31'b0, mem_we}, 32'd1);
      checkOutput("pre_rst_sticky", {31'b0, err_sticky}, 32'd1);
      nextCycle();
      rst = 1'b1;
      nextCycle();
      rst = 1'b0;
      mem_ready = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_we", {31'b0, mem_we}, 32'd0);
      checkOutput("post_rst_count", {25'b0, count}, 32'd0);
      checkOutput("post_rst_sticky", {31'b0, err_sticky}, 32'd0);
      checkOutput("post_rst_addr", {26'b0, mem_addr}, 32'd0);
      nextCycle();

      repeat (3) nextCycle();
      checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
